// File: rtl/link_upstream_credit_tx.sv
// Credit-flow link transmitter: accepts a WIDTH-bit core packet and serialises it
// LS slice first onto NUM_CH*CH_W-bit beats, one beat per cycle while credit is available.
module link_upstream_credit_tx #(
    parameter int WIDTH       = 64,
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 8,
    parameter int CREDITS     = 32,
    parameter int TOKEN_DECIM = 8,
    localparam int BEAT_W     = NUM_CH * CH_W,
    localparam int BEATS      = WIDTH / BEAT_W,
    localparam int CRED_W     = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid_i,
    input  logic [WIDTH-1:0]  core_data_i,
    output logic              core_ready_o,
    output logic              io_valid_o,
    output logic [BEAT_W-1:0] io_data_o,
    input  logic              io_token_i,
    output logic [CRED_W-1:0] credit_o,
    output logic [6:0]        sent_cnt_o,
    output logic              err_o,
    output logic              fsm_state_o
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TOK_W = $clog2(TOKEN_DECIM + 1);
    localparam int SUM_W = ((CRED_W > TOK_W) ? CRED_W : TOK_W) + 1;

    if ((BEATS < 1) || (BEATS * BEAT_W != WIDTH)) begin : g_bad_width
        $error("WIDTH must be an exact multiple of NUM_CH*CH_W");
    end

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CRED_W-1:0]  credit_q, credit_d;
    logic [6:0]         sent_q, sent_d;
    logic               err_q, err_d;
    logic               send, last, accept, overflow;
    logic [SUM_W-1:0]   credit_sum;

    // Handshake: a packet moves when core_valid_i && core_ready_o in the same cycle;
    // a beat is delivered on every cycle io_valid_o is 1 (no downstream ready, credits gate it).
    always_comb begin
        send         = (state_q == SEND) && (credit_q != '0) && !rst;
        last         = send && (idx_q == IDX_W'(BEATS - 1));
        core_ready_o = !rst && ((state_q == IDLE) || last);
        accept       = core_valid_i && core_ready_o;

        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                    shreg_d = core_data_i;
                end
            end
            SEND: begin
                if (last) begin
                    idx_d = '0;
                    if (accept) begin
                        shreg_d = core_data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (send) begin
                    idx_d   = idx_q + IDX_W'(1);
                    shreg_d = shreg_q >> BEAT_W;
                end
            end
            default: state_d = IDLE;
        endcase

        // Extra headroom bit keeps credit + token from wrapping before the saturation test.
        credit_sum = SUM_W'(credit_q) - SUM_W'(send)
                   + (io_token_i ? SUM_W'(TOKEN_DECIM) : SUM_W'(0));
        overflow   = credit_sum > SUM_W'(CREDITS);
        credit_d   = overflow ? CRED_W'(CREDITS) : credit_sum[CRED_W-1:0];
        sent_d     = sent_q + 7'(send);
        err_d      = err_q || overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            credit_q <= CRED_W'(CREDITS);
            sent_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end

    // Payload register needs no reset: it is only observed while io_valid_o is 1.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign io_valid_o  = send;
    assign io_data_o   = shreg_q[BEAT_W-1:0];
    assign credit_o    = credit_q;
    assign sent_cnt_o  = sent_q;
    assign err_o       = err_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_link_upstream_credit_tx.sv
// Directed bench for link_upstream_credit_tx at default parameters (4 beats x 16 bits,
// 32 credits, 8 credits per token); expected credit/count values come from a small model.
module tb_link_upstream_credit_tx;

    logic        clk;
    logic        rst;
    logic        core_valid;
    logic [63:0] core_data;
    logic        core_ready;
    logic        io_valid;
    logic [15:0] io_data;
    logic        io_token;
    logic [5:0]  credit;
    logic [6:0]  sent_cnt;
    logic        err;
    logic        fsm_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_credit;
    logic [6:0]  exp_sent;
    logic        exp_err;

    link_upstream_credit_tx dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid_i (core_valid),
        .core_data_i  (core_data),
        .core_ready_o (core_ready),
        .io_valid_o   (io_valid),
        .io_data_o    (io_data),
        .io_token_i   (io_token),
        .credit_o     (credit),
        .sent_cnt_o   (sent_cnt),
        .err_o        (err),
        .fsm_state_o  (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_credit = 32;
        exp_sent   = '0;
        exp_err    = 1'b0;
    endtask

    task automatic model_cycle(input logic beat, input logic tok);
        int nc;
        nc = exp_credit - (beat ? 1 : 0) + (tok ? 8 : 0);
        if (nc > 32) begin
            nc      = 32;
            exp_err = 1'b1;
        end
        exp_credit = nc;
        if (beat) exp_sent = exp_sent + 7'd1;
    endtask

    task automatic idle_check(input string tag);
        #1;
        check({tag, "_valid"},  64'(io_valid),   64'd0);
        check({tag, "_ready"},  64'(core_ready), 64'd1);
        check({tag, "_credit"}, 64'(credit),     64'(exp_credit));
        check({tag, "_sent"},   64'(sent_cnt),   64'(exp_sent));
        check({tag, "_err"},    64'(err),        64'(exp_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_valid = 1'b0;
        io_token = 1'b0;
        #1;
        check("rst_ready", 64'(core_ready), 64'd0);
        check("rst_valid", 64'(io_valid),   64'd0);
        next_cycle();
        rst = 1'b0;
        model_reset();
        idle_check("post_rst");
    endtask

    // driver: offer a packet in the current (idle) cycle
    task automatic accept(input logic [63:0] data);
        core_valid = 1'b1;
        core_data  = data;
        #1;
        check("accept_ready", 64'(core_ready), 64'd1);
        next_cycle();
        core_valid = 1'b0;
    endtask

    // drive nb beat cycles of a packet already accepted; tmask puts a token on beat k
    task automatic run_pkt(input logic [63:0] data, input logic [3:0] tmask, input int nb,
                           input logic nv, input logic [63:0] nd);
        logic [63:0] sh;
        for (int k = 0; k < nb; k++) begin
            io_token = tmask[k];
            if (k == 3) begin
                core_valid = nv;
                core_data  = nd;
            end
            #1;
            sh = data >> (16 * k);
            check("beat_valid",  64'(io_valid),   64'd1);
            check("beat_data",   64'(io_data),    64'(sh[15:0]));
            check("beat_credit", 64'(credit),     64'(exp_credit));
            check("beat_sent",   64'(sent_cnt),   64'(exp_sent));
            check("beat_ready",  64'(core_ready), (k == 3) ? 64'd1 : 64'd0);
            model_cycle(1'b1, tmask[k]);
            next_cycle();
            io_token   = 1'b0;
            core_valid = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] d2;
        rst        = 1'b1;
        core_valid = 1'b0;
        core_data  = '0;
        io_token   = 1'b0;
        model_reset();
        next_cycle();
        check("init_rst_ready", 64'(core_ready), 64'd0);
        next_cycle();
        rst = 1'b0;
        idle_check("reset");

        // single packet: 6677, 4455, 2233, 0011
        accept(64'h0011_2233_4455_6677);
        run_pkt(64'h0011_2233_4455_6677, 4'b0000, 4, 1'b0, '0);
        idle_check("pkt1_done");
        check("pkt1_credit28", 64'(credit),   64'd28);
        check("pkt1_sent4",    64'(sent_cnt), 64'd4);

        // drain all credit with seven more packets
        for (int i = 0; i < 7; i++) begin
            d = {$urandom, $urandom};
            accept(d);
            run_pkt(d, 4'b0000, 4, 1'b0, '0);
        end
        idle_check("drained");
        check("drained_credit0", 64'(credit), 64'd0);

        // ninth packet stalls at zero credit, token resumes it
        d = 64'hA1A2_B3B4_C5C6_D7D8;
        accept(d);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid",  64'(io_valid),   64'd0);
            check("stall_ready",  64'(core_ready), 64'd0);
            check("stall_credit", 64'(credit),     64'd0);
            next_cycle();
        end
        io_token = 1'b1;
        #1;
        check("token_cycle_valid", 64'(io_valid), 64'd0);
        model_cycle(1'b0, 1'b1);
        next_cycle();
        io_token = 1'b0;
        // beat 3 sees credit 5 together with a token: 5 - 1 + 8 = 12
        run_pkt(d, 4'b1000, 4, 1'b0, '0);
        idle_check("token_beat");
        check("token_beat_credit12", 64'(credit), 64'd12);

        // reset after beat 2: the remaining beat is discarded
        d = 64'h1111_2222_3333_4444;
        accept(d);
        run_pkt(d, 4'b0000, 3, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_check("after_mid_rst");
        end

        // token at credit 30 (mid-packet) overflows: saturate to 32, err sticky
        d = 64'h0F0E_0D0C_0B0A_0908;
        accept(d);
        run_pkt(d, 4'b0100, 4, 1'b0, '0);
        idle_check("overflow");
        check("overflow_err", 64'(err), 64'd1);
        io_token = 1'b1;
        #1;
        model_cycle(1'b0, 1'b1);
        next_cycle();
        io_token = 1'b0;
        idle_check("overflow_idle_token");
        next_cycle();
        idle_check("err_held");
        do_reset();

        // back-to-back packets: eight consecutive beats
        d  = 64'h0102_0304_0506_0708;
        d2 = 64'hF0E0_D0C0_B0A0_9080;
        accept(d);
        run_pkt(d, 4'b0000, 4, 1'b1, d2);
        run_pkt(d2, 4'b0000, 4, 1'b0, '0);
        idle_check("b2b");

        // 120 more beats wraps sent count through 127 -> 0
        for (int i = 0; i < 30; i++) begin
            d = {$urandom, $urandom};
            accept(d);
            run_pkt(d, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4, 1'b0, '0);
        end
        idle_check("wrap");
        check("wrap_sent0", 64'(sent_cnt), 64'd0);
        d = 64'h5555_6666_7777_8888;
        accept(d);
        run_pkt(d, 4'b0000, 4, 1'b0, '0);
        idle_check("post_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/link_upstream_credit_tx.md
LINK_UPSTREAM_CREDIT_TX -- requirements
Module: link_upstream_credit_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 64: core payload width in bits.
REQ-002 SHALL have parameter NUM_CH, default 2: number of parallel link channels.
REQ-003 SHALL have parameter CH_W, default 8: bits per channel per beat.
REQ-004 SHALL have parameter CREDITS, default 32: credit count after reset, and maximum credit count.
REQ-005 SHALL have parameter TOKEN_DECIM, default 8: credits returned per token pulse.
REQ-006 SHALL derive BEATS = WIDTH/(NUM_CH*CH_W); WIDTH not an exact multiple of NUM_CH*CH_W SHALL be an elaboration error.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 core_valid_i  in  1  core packet valid.
REQ-010 core_data_i  in  WIDTH  core packet.
REQ-011 core_ready_o  out  1  core may hand over a packet this cycle.
REQ-012 io_valid_o  out  1  beat on io_data_o is valid this cycle.
REQ-013 io_data_o  out  NUM_CH*CH_W  link beat; channel c drives bits [c*CH_W +: CH_W].
REQ-014 io_token_i  in  1  single-cycle token pulse from downstream, already in the clk domain.
REQ-015 credit_o  out  clog2(CREDITS+1)  credits currently available.
REQ-016 sent_cnt_o  out  7  total beats sent, modulo 128.
REQ-017 err_o  out  1  sticky credit-overflow flag.

Function
REQ-018 SHALL implement FSM {IDLE, SEND}; reset state IDLE.
REQ-019 Handshake: packet accepted on a cycle with core_valid_i && core_ready_o; accepted data SHALL be latched into an internal shift register.
REQ-020 core_ready_o SHALL be 1 in IDLE, and 1 in SEND only in a cycle where the last beat is sent; otherwise 0.
REQ-021 IDLE -> SEND on accept; SEND -> IDLE after the last beat unless a new packet is accepted in that same cycle (then remain in SEND with beat index 0).
REQ-022 Beat k (0..BEATS-1) SHALL carry core_data_i[k*NUM_CH*CH_W +: NUM_CH*CH_W]; LS slice first.
REQ-023 First beat SHALL be presented no earlier than the cycle after accept; a beat SHALL be sent (io_valid_o=1) in a SEND cycle iff credit_o > 0.
REQ-024 With credit_o = 0 in SEND: io_valid_o=0, io_data_o held at the pending beat, beat index unchanged.
REQ-025 io_valid_o SHALL be 0 in IDLE; io_data_o SHALL be don't-care when io_valid_o = 0.
REQ-026 Each sent beat consumes one credit and increments sent_cnt_o (wrap 127 -> 0).
REQ-027 Credit update per cycle: next = credit - sent + (io_token_i ? TOKEN_DECIM : 0); a simultaneous token and beat SHALL both be applied in the same cycle.
REQ-028 If next > CREDITS: credit_o SHALL saturate at CREDITS and err_o SHALL set, remaining 1 until reset.
REQ-029 Credit arithmetic SHALL use one extra bit internally so that no intermediate wrap-around occurs.

Reset
REQ-030 On rst: state IDLE, beat index 0, credit_o = CREDITS, sent_cnt_o = 0, err_o = 0, io_valid_o = 0.
REQ-031 core_ready_o SHALL be 0 in any cycle where rst = 1, and 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-packet SHALL discard the packet; no further beats of it are sent.

Verification (defaults: 4 beats x 16 bits)
REQ-033 After reset, accept 0x0011223344556677 at cycle N -> io_data_o = 0x6677, 0x4455, 0x2233, 0x0011 with io_valid_o=1 in cycles N+1..N+4; credit_o 32 -> 28; sent_cnt_o = 4.
REQ-034 Eight packets, no tokens -> credit_o = 0; a ninth packet is accepted but io_valid_o stays 0; one token pulse -> credit_o = 8 and beats resume the next cycle.
REQ-035 credit_o = 5 with a token and a beat in the same cycle -> credit_o = 12 next cycle.
REQ-036 credit_o = 30 and a token pulse -> credit_o = 32 and err_o = 1, held until rst.
REQ-037 rst asserted after beat 2 of a packet -> next cycle io_valid_o = 0, credit_o = 32, sent_cnt_o = 0; core_ready_o = 1 the cycle after rst deasserts.
REQ-038 Two back-to-back valid packets with ample credit -> 8 consecutive io_valid_o=1 cycles; core_ready_o = 1 in the 4th beat cycle; sent_cnt_o wraps correctly after 128 beats.
